ifft8_seq: RTL

//  Sequential 8-point radix-2 DIT inverse FFT; the return path for the 8-point FFT datapath.

---
 rtl/ifft_pkg.sv | 35 +++
 rtl/ifft_bfly.sv | 37 +++
 rtl/ifft8_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ifft_pkg.sv
// Shared types, constants and helpers for the 8-point sequential inverse FFT.
// The twiddle table holds conj(W8^t) in Q1.14.
package ifft_pkg;

  localparam int DW   = 16;
  localparam int TW   = 16;
  localparam int SW   = DW + 2;
  localparam int FRAC = 14;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  localparam logic signed [TW-1:0] TW_RE [0:3] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585};
  localparam logic signed [TW-1:0] TW_IM [0:3] = '{16'sd0, 16'sd11585, 16'sd16384, 16'sd11585};

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // Clamp a widened sum back into DW bits; in range when all dropped bits match the sign.
  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1:DW-1] == {(SW-DW+1){v[SW-1]}})
      return v[DW-1:0];
    return v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 butterfly: p = b*w (Q1.14, truncated), outputs halved
// and saturated so each stage scales by 1/2 and the frame by 1/8.
module ifft_bfly
  import ifft_pkg::*;
(
  input  cplx_t                a,
  input  cplx_t                b,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output cplx_t                y_top,
  output cplx_t                y_bot
);

  localparam int PW = DW + TW + 1;

  logic signed [PW-1:0] b_re, b_im, c_re, c_im, prod_re, prod_im;
  logic signed [SW-1:0] a_re, a_im, p_re, p_im;

  assign b_re = {{(PW-DW){b.re[DW-1]}}, b.re};
  assign b_im = {{(PW-DW){b.im[DW-1]}}, b.im};
  assign c_re = {{(PW-TW){w_re[TW-1]}}, w_re};
  assign c_im = {{(PW-TW){w_im[TW-1]}}, w_im};

  assign prod_re = b_re * c_re - b_im * c_im;
  assign prod_im = b_re * c_im + b_im * c_re;

  // |p| stays below ~46341, so keeping SW bits after the shift loses nothing.
  assign p_re = SW'(prod_re >>> FRAC);
  assign p_im = SW'(prod_im >>> FRAC);

  assign a_re = {{(SW-DW){a.re[DW-1]}}, a.re};
  assign a_im = {{(SW-DW){a.im[DW-1]}}, a.im};

  assign y_top = {sat((a_re + p_re) >>> 1), sat((a_im + p_im) >>> 1)};
  assign y_bot = {sat((a_re - p_re) >>> 1), sat((a_im - p_im) >>> 1)};

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT: bit-reversed load, 12 in-place
// butterflies (one per cycle), natural-order unload scaled by 1/8.
module ifft8_seq
  import ifft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last
);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  cplx_t       mem [0:7];
  logic [2:0]  top, bot;
  logic [1:0]  tw_idx;
  cplx_t       y_top, y_bot;

  // NOTE: every signal driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      LOAD: if (in_valid) begin
        if (cnt == 4'd7) begin
          state_next = COMPUTE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      COMPUTE: begin
        if (cnt == 4'd11) begin
          state_next = UNLOAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      UNLOAD: if (out_ready) begin
        if (cnt == 4'd7) begin
          state_next = LOAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: begin
        state_next = LOAD;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // In COMPUTE, cnt[3:2] is the stage and cnt[1:0] the butterfly within it.
  always_comb begin
    top    = '0;
    bot    = '0;
    tw_idx = '0;
    unique case (cnt[3:2])
      2'd0: begin
        top = {cnt[1:0], 1'b0};
        bot = {cnt[1:0], 1'b1};
      end
      2'd1: begin
        top    = {cnt[1], 1'b0, cnt[0]};
        bot    = {cnt[1], 1'b1, cnt[0]};
        tw_idx = {cnt[0], 1'b0};
      end
      2'd2: begin
        top    = {1'b0, cnt[1:0]};
        bot    = {1'b1, cnt[1:0]};
        tw_idx = cnt[1:0];
      end
      default: ;
    endcase
  end

  ifft_bfly u_bfly (
    .a     (mem[top]),
    .b     (mem[bot]),
    .w_re  (TW_RE[tw_idx]),
    .w_im  (TW_IM[tw_idx]),
    .y_top (y_top),
    .y_bot (y_bot)
  );

  // NOTE: the sample buffer is deliberately not reset; its contents are rewritten by every load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == LOAD && in_valid) begin
        mem[bitrev3(cnt[2:0])] <= {in_re, in_im};
      end else if (state == COMPUTE) begin
        mem[top] <= y_top;
        mem[bot] <= y_bot;
      end
    end
  end

  // Buffer and cnt are frozen in UNLOAD while stalled, so outputs hold by construction.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign out_last  = out_valid && (cnt[2:0] == 3'd7);
  assign out_re    = out_valid ? mem[cnt[2:0]].re : '0;
  assign out_im    = out_valid ? mem[cnt[2:0]].im : '0;

endmodule
